dmem_arbiter: RTL and testbench

Two-port arbiter and burst sequencer in front of the 64-byte doubleword data memory. It shares the memory between the pipeline MEM stage (port A) and a program/data loader (port B). It runs fair round-robin arbitration, sequences loader bursts of up to MAX_BURST doublewords with auto-incremented addresses, and rejects misaligned or out-of-range accesses. All memory-facing signals are driven combinationally from the granted requester, and responses are registered.

---
 rtl/dmem_arbiter.sv | 267 ++++++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the doubleword data memory between the pipeline MEM
// stage (port A) and the program/data loader (port B). Ties are settled by
// round-robin. Loader bursts run with auto-incremented addresses.
// Misaligned or out-of-range accesses are answered with an error response
// and never reach the memory.
module dmem_arbiter #(
    parameter int MEM_BYTES = 64,
    parameter int MAX_BURST = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_a_req,
    input  logic        i_a_we,
    input  logic [63:0] i_a_addr,
    input  logic [63:0] i_a_wdata,
    output logic        o_a_gnt,
    output logic        o_a_rvalid,
    output logic        o_a_err,
    output logic [63:0] o_a_rdata,

    input  logic        i_b_req,
    input  logic        i_b_we,
    input  logic [63:0] i_b_addr,
    input  logic [63:0] i_b_wdata,
    input  logic [3:0]  i_b_len,
    output logic        o_b_gnt,
    output logic        o_b_rvalid,
    output logic        o_b_err,
    output logic        o_b_done,
    output logic [63:0] o_b_rdata,

    output logic [63:0] o_mem_address,
    output logic [63:0] o_mem_write_data,
    output logic        o_mem_memorywrite,
    output logic        o_mem_memoryread,
    input  logic [63:0] i_mem_read_data
);

    // Highest legal doubleword address and the burst length ceiling.
    localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);
    localparam logic [3:0]  MAX_LEN   = 4'(MAX_BURST);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        r_prioB;
    logic [63:0] r_base;
    logic [3:0]  r_idx;
    logic [3:0]  r_len;
    logic        r_bwe;

    logic        r_aRvalid;
    logic        r_aErr;
    logic [63:0] r_aRdata;
    logic        r_bRvalid;
    logic        r_berr;
    logic        r_bDone;
    logic [63:0] r_bRdata;

    logic        w_aLegal;
    logic [3:0]  w_bLen;
    logic [63:0] w_bSpan;
    logic [63:0] w_bEnd;
    logic        w_bLegal;
    logic [63:0] w_beatAddr;
    logic        w_lastBeat;

    logic        w_aGrant;
    logic        w_bStart;
    logic        w_bBeat;

    // Port A legality: doubleword aligned and inside the memory.
    assign w_aLegal = (i_a_addr[2:0] == 3'b000) && (i_a_addr <= LAST_ADDR);

    // Effective burst length: zero means a single beat, long requests are clamped.
    always_comb begin
        w_bLen = i_b_len;
        if (i_b_len == 4'd0) begin
            w_bLen = 4'd1;
        end else if (i_b_len > MAX_LEN) begin
            w_bLen = MAX_LEN;
        end
    end

    // The base is checked first, so the end address cannot wrap when it matters.
    assign w_bSpan    = 64'(w_bLen - 4'd1) << 3;
    assign w_bEnd     = i_b_addr + w_bSpan;
    assign w_bLegal   = (i_b_addr[2:0] == 3'b000) && (i_b_addr <= LAST_ADDR) &&
                        (w_bEnd <= LAST_ADDR);

    assign w_beatAddr = r_base + (64'(r_idx) << 3);
    assign w_lastBeat = (r_idx == (r_len - 4'd1));

    // Arbitration and next state; nothing is granted while reset is held.
    always_comb begin
        w_nextState = r_state;
        w_aGrant    = 1'b0;
        w_bStart    = 1'b0;
        w_bBeat     = 1'b0;
        if (!i_reset) begin
            case (r_state)
                S_IDLE: begin
                    if (i_a_req && (!i_b_req || !r_prioB)) begin
                        w_aGrant = 1'b1;
                    end else if (i_b_req) begin
                        w_bStart = 1'b1;
                        if (w_bLegal && (w_bLen > 4'd1)) begin
                            w_nextState = S_BURST;
                        end
                    end
                end
                S_BURST: begin
                    if (i_b_req) begin
                        w_bBeat = 1'b1;
                        if (w_lastBeat) begin
                            w_nextState = S_IDLE;
                        end
                    end else if (i_a_req) begin
                        w_aGrant = 1'b1;
                    end
                end
                default: begin
                    w_nextState = S_IDLE;
                end
            endcase
        end
    end

    assign o_a_gnt = w_aGrant;
    assign o_b_gnt = w_bStart | w_bBeat;

    // Memory port follows the granted requester; erroneous grants leave it idle.
    always_comb begin
        o_mem_address     = '0;
        o_mem_write_data  = '0;
        o_mem_memorywrite = 1'b0;
        o_mem_memoryread  = 1'b0;
        if (w_aGrant && w_aLegal) begin
            o_mem_address     = i_a_addr;
            o_mem_write_data  = i_a_wdata;
            o_mem_memorywrite = i_a_we;
            o_mem_memoryread  = !i_a_we;
        end else if (w_bStart && w_bLegal) begin
            o_mem_address     = i_b_addr;
            o_mem_write_data  = i_b_wdata;
            o_mem_memorywrite = i_b_we;
            o_mem_memoryread  = !i_b_we;
        end else if (w_bBeat) begin
            o_mem_address     = w_beatAddr;
            o_mem_write_data  = i_b_wdata;
            o_mem_memorywrite = r_bwe;
            o_mem_memoryread  = !r_bwe;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Round-robin priority and burst context; a paused burst keeps its priority.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prioB <= 1'b0;
            r_base  <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_bwe   <= 1'b0;
        end else begin
            if (w_aGrant && (r_state == S_IDLE)) begin
                r_prioB <= 1'b1;
            end
            if (w_bStart) begin
                if (w_bLegal) begin
                    r_base <= i_b_addr;
                    r_len  <= w_bLen;
                    r_idx  <= 4'd1;
                    r_bwe  <= i_b_we;
                    if (w_bLen == 4'd1) begin
                        r_prioB <= 1'b0;
                    end
                end else begin
                    r_prioB <= 1'b0;
                end
            end
            if (w_bBeat) begin
                r_idx <= r_idx + 4'd1;
                if (w_lastBeat) begin
                    r_prioB <= 1'b0;
                end
            end
        end
    end

    // Registered responses: one-cycle pulses, read data captured at the grant edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_aRvalid <= 1'b0;
            r_aErr    <= 1'b0;
            r_aRdata  <= '0;
            r_bRvalid <= 1'b0;
            r_berr    <= 1'b0;
            r_bDone   <= 1'b0;
            r_bRdata  <= '0;
        end else begin
            r_aRvalid <= 1'b0;
            r_aErr    <= 1'b0;
            r_bRvalid <= 1'b0;
            r_berr    <= 1'b0;
            r_bDone   <= 1'b0;
            if (w_aGrant) begin
                if (w_aLegal) begin
                    if (!i_a_we) begin
                        r_aRvalid <= 1'b1;
                        r_aRdata  <= i_mem_read_data;
                    end
                end else begin
                    r_aRvalid <= 1'b1;
                    r_aErr    <= 1'b1;
                    r_aRdata  <= '0;
                end
            end
            if (w_bStart) begin
                if (w_bLegal) begin
                    if (!i_b_we) begin
                        r_bRvalid <= 1'b1;
                        r_bRdata  <= i_mem_read_data;
                    end
                    if (w_bLen == 4'd1) begin
                        r_bDone <= 1'b1;
                    end
                end else begin
                    r_berr  <= 1'b1;
                    r_bDone <= 1'b1;
                end
            end
            if (w_bBeat) begin
                if (!r_bwe) begin
                    r_bRvalid <= 1'b1;
                    r_bRdata  <= i_mem_read_data;
                end
                if (w_lastBeat) begin
                    r_bDone <= 1'b1;
                end
            end
        end
    end

    assign o_a_rvalid = r_aRvalid;
    assign o_a_err    = r_aErr;
    assign o_a_rdata  = r_aRdata;
    assign o_b_rvalid = r_bRvalid;
    assign o_b_err    = r_berr;
    assign o_b_done   = r_bDone;
    assign o_b_rdata  = r_bRdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus for dmem_arbiter with a behavioural
// 8-doubleword memory. Expected responses are queued by the stimulus and
// popped by a monitor whenever the DUT presents a response.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        aReq, aWe, bReq, bWe;
    logic [63:0] aAddr, aWdata, bAddr, bWdata;
    logic [3:0]  bLen;
    logic        aGnt, aRvalid, aErr, bGnt, bRvalid, bErr, bDone;
    logic [63:0] aRdata, bRdata;
    logic [63:0] memAddress, memWdata, memRdata;
    logic        memWrite, memRead;

    logic        memInit;
    logic [63:0] memModel [8];
    logic [63:0] expMem [8];

    typedef struct packed {
        logic        err;
        logic [63:0] rdata;
    } aResp_t;

    typedef struct packed {
        logic        rvalid;
        logic        err;
        logic        done;
        logic [63:0] rdata;
    } bResp_t;

    aResp_t aQ [$];
    bResp_t bQ [$];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.MEM_BYTES(64), .MAX_BURST(8)) dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_a_req           (aReq),
        .i_a_we            (aWe),
        .i_a_addr          (aAddr),
        .i_a_wdata         (aWdata),
        .o_a_gnt           (aGnt),
        .o_a_rvalid        (aRvalid),
        .o_a_err           (aErr),
        .o_a_rdata         (aRdata),
        .i_b_req           (bReq),
        .i_b_we            (bWe),
        .i_b_addr          (bAddr),
        .i_b_wdata         (bWdata),
        .i_b_len           (bLen),
        .o_b_gnt           (bGnt),
        .o_b_rvalid        (bRvalid),
        .o_b_err           (bErr),
        .o_b_done          (bDone),
        .o_b_rdata         (bRdata),
        .o_mem_address     (memAddress),
        .o_mem_write_data  (memWdata),
        .o_mem_memorywrite (memWrite),
        .o_mem_memoryread  (memRead),
        .i_mem_read_data   (memRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write committed at the clock edge.
    always_comb begin
        memRdata = '0;
        if (memAddress < 64'd64) memRdata = memModel[memAddress[5:3]];
    end

    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 8; i++) memModel[i] <= 64'hC0DE_0000_0000_0000 + 64'(i);
        end else if (memWrite && (memAddress < 64'd64)) begin
            memModel[memAddress[5:3]] <= memWdata;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushA(input logic err, input logic [63:0] rdata);
        aResp_t e;
        e.err = err;
        e.rdata = rdata;
        aQ.push_back(e);
    endtask

    task automatic pushB(input logic rvalid, input logic err, input logic done,
                         input logic [63:0] rdata);
        bResp_t e;
        e.rvalid = rvalid;
        e.err = err;
        e.done = done;
        e.rdata = rdata;
        bQ.push_back(e);
    endtask

    // Monitor: every response the DUT presents must match the head of its queue.
    always @(negedge clk) begin
        aResp_t ea;
        bResp_t eb;
        if (aRvalid || aErr) begin
            if (aQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL a_resp_unexpected: rvalid=%0b err=%0b rdata=0x%0h, expected none at %0t",
                         aRvalid, aErr, aRdata, $time);
            end else begin
                ea = aQ.pop_front();
                checkOutput("a_rvalid", 64'(aRvalid), 64'd1);
                checkOutput("a_err", 64'(aErr), 64'(ea.err));
                checkOutput("a_rdata", aRdata, ea.rdata);
            end
        end
        if (bRvalid || bErr || bDone) begin
            if (bQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL b_resp_unexpected: rvalid=%0b err=%0b done=%0b, expected none at %0t",
                         bRvalid, bErr, bDone, $time);
            end else begin
                eb = bQ.pop_front();
                checkOutput("b_rvalid", 64'(bRvalid), 64'(eb.rvalid));
                checkOutput("b_err", 64'(bErr), 64'(eb.err));
                checkOutput("b_done", 64'(bDone), 64'(eb.done));
                if (eb.rvalid) checkOutput("b_rdata", bRdata, eb.rdata);
            end
        end
    end

    // One cycle of stimulus, entered 1 time unit after a rising edge.
    task automatic applyStimulus(input string tag,
                                 input logic ar, input logic aw, input logic [63:0] aa,
                                 input logic [63:0] ad,
                                 input logic br, input logic bw, input logic [63:0] ba,
                                 input logic [63:0] bd, input logic [3:0] bl,
                                 input logic expAGnt, input logic expBGnt,
                                 input logic expWe, input logic expRe);
        aReq = ar; aWe = aw; aAddr = aa; aWdata = ad;
        bReq = br; bWe = bw; bAddr = ba; bWdata = bd; bLen = bl;
        #3;
        checkOutput({tag, ".a_gnt"}, 64'(aGnt), 64'(expAGnt));
        checkOutput({tag, ".b_gnt"}, 64'(bGnt), 64'(expBGnt));
        checkOutput({tag, ".mem_we"}, 64'(memWrite), 64'(expWe));
        checkOutput({tag, ".mem_re"}, 64'(memRead), 64'(expRe));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
    endtask

    // Reset with both requests high: no grants, no memory access, outputs cleared.
    task automatic resetDut(input int n);
        reset = 1'b1;
        aReq = 1; aWe = 1; aAddr = 64'h08; aWdata = 64'hBAD;
        bReq = 1; bWe = 1; bAddr = 64'h00; bWdata = 64'hBAD; bLen = 4'd8;
        for (int i = 0; i < n; i++) begin
            #3;
            checkOutput("rst.a_gnt", 64'(aGnt), 64'd0);
            checkOutput("rst.b_gnt", 64'(bGnt), 64'd0);
            checkOutput("rst.mem_we", 64'(memWrite), 64'd0);
            checkOutput("rst.mem_re", 64'(memRead), 64'd0);
            if (i > 0) begin
                checkOutput("rst.a_rvalid", 64'(aRvalid), 64'd0);
                checkOutput("rst.a_err", 64'(aErr), 64'd0);
                checkOutput("rst.a_rdata", aRdata, 64'd0);
                checkOutput("rst.b_rvalid", 64'(bRvalid), 64'd0);
                checkOutput("rst.b_err", 64'(bErr), 64'd0);
                checkOutput("rst.b_done", 64'(bDone), 64'd0);
                checkOutput("rst.b_rdata", bRdata, 64'd0);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        aReq = 0;
        bReq = 0;
    endtask

    task automatic checkMemory(input string tag);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("%s.mem[%0d]", tag, i), memModel[i], expMem[i]);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) expMem[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
        memInit = 1'b1;
        resetDut(2);
        memInit = 1'b0;

        // Single A write then A read of the same doubleword.
        applyStimulus("a_wr", 1, 1, 64'h10, 64'h1122334455667788, 0, 0, 0, 0, 4'd0, 1, 0, 1, 0);
        expMem[2] = 64'h1122334455667788;
        pushA(0, 64'h1122334455667788);
        applyStimulus("a_rd", 1, 0, 64'h10, 0, 0, 0, 0, 0, 4'd0, 1, 0, 0, 1);
        idle(1);

        // Full-length B write burst from 0x00 with data 1..8.
        for (int k = 0; k < 8; k++) begin
            if (k == 7) pushB(0, 0, 1, 0);
            applyStimulus("b_wr", 0, 0, 0, 0, 1, 1, 64'h00, 64'(k + 1), 4'd8, 0, 1, 1, 0);
            expMem[k] = 64'(k + 1);
        end
        idle(2);
        checkMemory("burst");

        // Tie after reset goes to A, then B gets both beats, then A again.
        resetDut(2);
        pushA(0, 64'd2);
        applyStimulus("tie0", 1, 0, 64'h08, 0, 1, 0, 64'h00, 0, 4'd2, 1, 0, 0, 1);
        pushB(1, 0, 0, 64'd1);
        applyStimulus("tie1", 1, 0, 64'h08, 0, 1, 0, 64'h00, 0, 4'd2, 0, 1, 0, 1);
        pushB(1, 0, 1, 64'd2);
        applyStimulus("tie2", 1, 0, 64'h08, 0, 1, 0, 64'h00, 0, 4'd2, 0, 1, 0, 1);
        pushA(0, 64'd8);
        applyStimulus("tie3", 1, 0, 64'h38, 0, 1, 0, 64'h00, 0, 4'd2, 1, 0, 0, 1);
        idle(1);

        // Paused B read burst from 0x20 with A served during the pause.
        pushB(1, 0, 0, 64'd5);
        applyStimulus("pause0", 0, 0, 0, 0, 1, 0, 64'h20, 0, 4'd4, 0, 1, 0, 1);
        pushB(1, 0, 0, 64'd6);
        applyStimulus("pause1", 0, 0, 0, 0, 1, 0, 64'h20, 0, 4'd4, 0, 1, 0, 1);
        pushA(0, 64'd3);
        applyStimulus("pause2", 1, 0, 64'h10, 0, 0, 0, 64'h20, 0, 4'd4, 1, 0, 0, 1);
        applyStimulus("pause3", 1, 1, 64'h00, 64'hDEAD_BEEF_0000_0001, 0, 0, 64'h20, 0, 4'd4, 1, 0, 1, 0);
        expMem[0] = 64'hDEAD_BEEF_0000_0001;
        pushB(1, 0, 0, 64'd7);
        applyStimulus("pause4", 0, 0, 0, 0, 1, 1, 64'h00, 0, 4'd1, 0, 1, 0, 1);
        pushB(1, 0, 1, 64'd8);
        applyStimulus("pause5", 0, 0, 0, 0, 1, 1, 64'h00, 0, 4'd1, 0, 1, 0, 1);

        // Errors and burst length boundaries.
        pushA(0, 64'hDEAD_BEEF_0000_0001);
        applyStimulus("err_tie", 1, 0, 64'h00, 0, 1, 1, 64'h30, 64'h55, 4'd4, 1, 0, 0, 1);
        pushB(0, 1, 1, 0);
        applyStimulus("b_oob", 0, 0, 0, 0, 1, 1, 64'h30, 64'h55, 4'd4, 0, 1, 0, 0);
        pushA(1, 0);
        applyStimulus("a_mis", 1, 0, 64'h3C, 0, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0);
        pushA(1, 0);
        applyStimulus("a_oob", 1, 1, 64'h40, 64'h77, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0);
        pushB(1, 0, 1, 64'd8);
        applyStimulus("b_len0", 0, 0, 0, 0, 1, 0, 64'h38, 0, 4'd0, 0, 1, 0, 1);
        for (int k = 0; k < 8; k++) begin
            pushB(1, 0, (k == 7), expMem[k]);
            applyStimulus("b_clamp", 0, 0, 0, 0, 1, 0, 64'h00, 0, (k == 0) ? 4'd15 : 4'd1, 0, 1, 0, 1);
        end
        idle(2);
        checkMemory("errors");

        // Reset part-way through a B write burst.
        pushA(0, 64'd8);
        applyStimulus("pre_rst", 1, 0, 64'h38, 0, 0, 0, 0, 0, 4'd0, 1, 0, 0, 1);
        idle(1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus("rst_burst", 0, 0, 0, 0, 1, 1, 64'h00, 64'h100 + 64'(k), 4'd8, 0, 1, 1, 0);
            expMem[k] = 64'h100 + 64'(k);
        end
        resetDut(2);
        idle(3);
        checkMemory("midrst");

        checkOutput("a_queue_drained", 64'(aQ.size()), 64'd0);
        checkOutput("b_queue_drained", 64'(bQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
